fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register of the RV32I core. Holds the PC, issues single-outstanding requests to instruction memory, captures returned words into IF/ID, and drives the 7-bit opcode field straight into the main control decoder one stage downstream. Handles hazard-unit stalls, branch redirects from EX, and discarding of in-flight fetches after a redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold IF/ID contents (hazard unit)
- redirect  in  1  flush and load new PC (branch taken in EX)
- redirect_pc  in  32  target PC; bits [1:0] forced to 0 internally
- imem_req  out  1  fetch request, one-cycle pulse
- imem_addr  out  32  fetch address, equals current PC
- imem_rvalid  in  1  response valid, one cycle, ≥1 cycle after imem_req
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  32  PC of IF/ID instruction
- if_id_instr  out  32  IF/ID instruction; 32'h0 when bubble
- if_id_opcode  out  7  if_id_instr[6:0], feeds control decoder
- perf_fetched  out  32  instructions loaded into IF/ID (see Configuration)

## Operation
- States: IDLE, ISSUE, WAIT, HOLD, DROP. imem_req = (state==ISSUE); imem_addr = pc.
- Reset: state IDLE, pc=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_instr=0, perf_fetched=0. Bubble word 0 yields opcode 0, decoded as all-zero controls.
- IDLE → ISSUE unconditionally.
- ISSUE → WAIT; pc unchanged until response.
- WAIT, imem_rvalid: if (!stall || !if_id_valid) load IF/ID {1, pc, imem_rdata}, pc+=4, → ISSUE; else save word/pc to hold buffer, pc+=4, → HOLD.
- HOLD: when !stall, load IF/ID from hold buffer, → ISSUE.
- IF/ID not loaded and !stall: becomes bubble (valid=0, instr=0). stall=1: IF/ID unchanged.
- redirect (highest priority, any state except IDLE): pc←{redirect_pc[31:2],2'b00}; IF/ID bubbled even if stall=1; hold buffer discarded. From WAIT without same-cycle imem_rvalid → DROP; otherwise → ISSUE.
- DROP: ignore next imem_rvalid, then → ISSUE. Redirect in DROP updates pc, stays DROP.
- pc arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- Reset asserted mid-fetch: immediate return to reset values; a later stray imem_rvalid in IDLE is ignored.

## Timing
- Memory latency L ≥ 1: request cycle n, response n+L, IF/ID updated at the edge ending n+L, next imem_req in n+L+1. Throughput one instruction per L+1 cycles.
- After reset deassertion: IDLE one cycle, first imem_req next cycle with addr RESET_PC.
- Redirect in cycle t: new pc visible t+1; IF/ID bubble from t+1; first fetch of target at t+1 (ISSUE path) or one cycle after discarded response (DROP path).
- All outputs registered or decoded from state/pc only; no input-to-output combinational path.

## Configuration
- FETCH_PERF_EN defined: perf_fetched increments by 1 on every IF/ID load with valid=1 (wraps at 2^32), reset to 0.
- Undefined: counter logic omitted, perf_fetched tied to 32'h0.

## Test plan
- Reset release, L=1 memory returning addr as data: imem_req at cycles 1,3,5 with addr 0,4,8; if_id_instr 0,4,8 at cycles 3,5,7; if_id_opcode = instr[6:0].
- stall=1 with IF/ID valid when response for addr 8 arrives → HOLD, IF/ID keeps addr 4 word; stall released → IF/ID = addr 8 word next edge, imem_req addr 12 following cycle.
- redirect to 32'h0000_0103 while WAIT (L=3) → pc=32'h100, IF/ID bubble, stale response discarded, next imem_req addr 32'h100.
- redirect same cycle as imem_rvalid → response dropped, imem_req addr redirect target next cycle; redirect with stall=1 → IF/ID valid=0.
- RESET_PC=32'hFFFF_FFFC → fetches FFFF_FFFC then 0.
- With FETCH_PERF_EN, 10 fetches plus 1 redirect-discarded response → perf_fetched=10; without macro → 0.

Source files
------------

// File: rtl/fetch_stage.sv
//-----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage and IF/ID pipeline register of the RV32I core.
// Holds the PC and issues one outstanding request at a time to instruction
// memory. Each returned word is captured into IF/ID, and its opcode field is
// driven straight into the main control decoder one stage downstream. The
// stage handles hazard-unit stalls, branch redirects from EX, and discards a
// fetch that is still in flight when a redirect arrives.
//
// Optional feature macro:
//   FETCH_PERF_EN  - when defined, perf_fetched counts IF/ID loads with
//                    valid=1 (wraps at 2^32). When undefined, the counter
//                    logic is omitted and perf_fetched is tied to 0.
//
// Parameters:
//   RESET_PC      PC loaded on reset (bits [1:0] are ignored)
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   stall         hold IF/ID contents (hazard unit)
//   redirect      flush the pipeline and load redirect_pc (branch taken in EX)
//   redirect_pc   redirect target; bits [1:0] are forced to 0
//   imem_req      fetch request, a one-cycle pulse
//   imem_addr     fetch address, equal to the current PC
//   imem_rvalid   response valid, one cycle, at least one cycle after imem_req
//   imem_rdata    instruction word, valid together with imem_rvalid
//   if_id_valid   IF/ID holds a real instruction
//   if_id_pc      PC of the IF/ID instruction
//   if_id_instr   IF/ID instruction; 32'h0 for a bubble
//   if_id_opcode  if_id_instr[6:0], feeds the control decoder
//   perf_fetched  count of instructions loaded into IF/ID
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [6:0]  if_id_opcode,
  output logic [31:0] perf_fetched
);

  // Clearing the low bits with a mask keeps word alignment while still
  // consuming every input bit.
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    S_IDLE,   // one cycle after reset before the first fetch
    S_ISSUE,  // imem_req asserted for the current PC
    S_WAIT,   // waiting for the response to the outstanding request
    S_HOLD,   // response captured while IF/ID was stalled
    S_DROP    // the outstanding response belongs to a redirected-away path
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        if_id_valid_q;
  logic [31:0] if_id_pc_q;
  logic [31:0] if_id_instr_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_instr_q;

  // Strobes that the next-state logic passes to the datapath
  logic take_redirect;
  logic load_mem;
  logic load_hold;
  logic save_hold;
  logic pc_inc;

  //---------------------------------------------------------------------------
  // State register
  //---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments (<=). All registers
  // then update together at the clock edge, and results do not depend on the
  // order in which the blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  //---------------------------------------------------------------------------
  // Next-state logic and datapath strobes
  //---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before any branch. A path
  // that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    take_redirect = 1'b0;
    load_mem      = 1'b0;
    load_hold     = 1'b0;
    save_hold     = 1'b0;
    pc_inc        = 1'b0;

    if (redirect && state_q != S_IDLE) begin
      // A redirect beats everything else. A same-cycle response belongs to
      // the old path, so it is dropped. A request that is still outstanding
      // must have its response swallowed later, in DROP.
      take_redirect = 1'b1;
      if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid)
        state_d = S_DROP;
      else
        state_d = S_ISSUE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            pc_inc = 1'b1;
            // An empty IF/ID can take the word even while stalled.
            if (!stall || !if_id_valid_q) begin
              load_mem = 1'b1;
              state_d  = S_ISSUE;
            end else begin
              save_hold = 1'b1;
              state_d   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load_hold = 1'b1;
            state_d   = S_ISSUE;
          end
        end
        S_DROP: begin
          if (imem_rvalid) state_d = S_ISSUE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  //---------------------------------------------------------------------------
  // Output decode (state and PC only; no path from inputs to outputs)
  //---------------------------------------------------------------------------
  always_comb begin
    imem_req  = (state_q == S_ISSUE);
    imem_addr = pc_q;
  end

  //---------------------------------------------------------------------------
  // PC, hold buffer and IF/ID register
  //---------------------------------------------------------------------------
  // NOTE: the hold buffer is reset along with everything else. It is only
  // two words, and resetting it keeps the contents deterministic after reset
  // for debug, even though they are never consumed before a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC & PC_MASK;
      hold_pc_q     <= 32'h0;
      hold_instr_q  <= 32'h0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= 32'h0;
    end else begin
      // PC arithmetic wraps naturally at 2^32.
      if (take_redirect) pc_q <= redirect_pc & PC_MASK;
      else if (pc_inc)   pc_q <= pc_q + 32'd4;

      if (save_hold) begin
        hold_pc_q    <= pc_q;
        hold_instr_q <= imem_rdata;
      end

      // A redirect flushes IF/ID even under stall, because that instruction
      // is on the wrong path.
      if (take_redirect) begin
        if_id_valid_q <= 1'b0;
        if_id_instr_q <= 32'h0;
      end else if (load_mem) begin
        if_id_valid_q <= 1'b1;
        if_id_pc_q    <= pc_q;
        if_id_instr_q <= imem_rdata;
      end else if (load_hold) begin
        if_id_valid_q <= 1'b1;
        if_id_pc_q    <= hold_pc_q;
        if_id_instr_q <= hold_instr_q;
      end else if (!stall) begin
        if_id_valid_q <= 1'b0;
        if_id_instr_q <= 32'h0;
      end
    end
  end

  assign if_id_valid  = if_id_valid_q;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_instr  = if_id_instr_q;
  // A bubble word of 0 gives opcode 0, which the decoder maps to all-zero
  // controls.
  assign if_id_opcode = if_id_instr_q[6:0];

  //---------------------------------------------------------------------------
  // Performance counter
  //---------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        perf_q <= 32'h0;
    else if (load_mem || load_hold) perf_q <= perf_q + 32'd1;
  end

  assign perf_fetched = perf_q;
`else
  assign perf_fetched = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps

module tb_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT, RESET_PC = 0
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [6:0]  if_id_opcode;
  logic [31:0] perf_fetched;

  // Wrap DUT, RESET_PC = FFFF_FFFC
  logic        rst_w = 1'b1;
  logic        stall_w = 1'b0;
  logic        redirect_w = 1'b0;
  logic [31:0] redirect_pc_w = 32'h0;
  logic        rvalid_w = 1'b0;
  logic [31:0] rdata_w = 32'h0;
  logic        req_w;
  logic [31:0] addr_w;
  logic        valid_w;
  logic [31:0] pc_w;
  logic [31:0] instr_w;
  logic [6:0]  opcode_w;
  logic [31:0] perf_w;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_perf;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_opcode(if_id_opcode), .perf_fetched(perf_fetched)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .stall(stall_w), .redirect(redirect_w),
    .redirect_pc(redirect_pc_w), .imem_req(req_w), .imem_addr(addr_w),
    .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
    .if_id_valid(valid_w), .if_id_pc(pc_w), .if_id_instr(instr_w),
    .if_id_opcode(opcode_w), .perf_fetched(perf_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; one-cycle pulses are cleared right after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    rvalid_w    = 1'b0;
  endtask

  initial begin
    // ---------------- Reset state ----------------
    step(); step();
    check("rst_valid",  {31'h0, if_id_valid}, 32'h0);
    check("rst_instr",  if_id_instr, 32'h0);
    check("rst_pc",     if_id_pc, 32'h0);
    check("rst_opcode", {25'h0, if_id_opcode}, 32'h0);
    check("rst_perf",   perf_fetched, 32'h0);
    check("rst_addr",   imem_addr, 32'h0);
    rst = 1'b0;                                  // cycle 0: IDLE
    check("idle_req",   {31'h0, imem_req}, 32'h0);

    // ---------------- L=1, data = address ----------------
    step();                                      // c1 ISSUE
    check("c1_req",  {31'h0, imem_req}, 32'h1);
    check("c1_addr", imem_addr, 32'h0);
    step();                                      // c2 WAIT
    check("c2_req",  {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0;
    step();                                      // c3 ISSUE
    check("c3_addr",  imem_addr, 32'h4);
    check("c3_valid", {31'h0, if_id_valid}, 32'h1);
    check("c3_instr", if_id_instr, 32'h0);
    check("c3_pc",    if_id_pc, 32'h0);
    step();                                      // c4 WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h4;
    step();                                      // c5 ISSUE
    check("c5_req",    {31'h0, imem_req}, 32'h1);
    check("c5_addr",   imem_addr, 32'h8);
    check("c5_instr",  if_id_instr, 32'h4);
    check("c5_opcode", {25'h0, if_id_opcode}, 32'h4);

    // ---------------- Stall -> HOLD ----------------
    stall = 1'b1;
    step();                                      // c6 WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h8;
    step();                                      // c7 HOLD
    check("hold_req",   {31'h0, imem_req}, 32'h0);
    check("hold_instr", if_id_instr, 32'h4);
    check("hold_valid", {31'h0, if_id_valid}, 32'h1);
    step();                                      // c8 HOLD
    check("hold2_instr", if_id_instr, 32'h4);
    stall = 1'b0;
    step();                                      // c9 ISSUE
    check("rel_instr", if_id_instr, 32'h8);
    check("rel_pc",    if_id_pc, 32'h8);
    check("rel_req",   {31'h0, imem_req}, 32'h1);
    check("rel_addr",  imem_addr, 32'hC);
    step();                                      // c10 WAIT, bubble
    check("bub_valid",  {31'h0, if_id_valid}, 32'h0);
    check("bub_opcode", {25'h0, if_id_opcode}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hC;
    step();                                      // c11 ISSUE addr 16
    check("c11_instr", if_id_instr, 32'hC);
    check("c11_addr",  imem_addr, 32'h10);

    // ---------------- Redirect while WAIT (L=3) ----------------
    step();                                      // c12 WAIT
    step();                                      // c13 WAIT
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();                                      // c14 DROP
    check("drop_addr",  imem_addr, 32'h100);
    check("drop_req",   {31'h0, imem_req}, 32'h0);
    check("drop_valid", {31'h0, if_id_valid}, 32'h0);
    check("drop_instr", if_id_instr, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;  // stale response
    step();                                      // c15 ISSUE
    check("tgt_req",   {31'h0, imem_req}, 32'h1);
    check("tgt_addr",  imem_addr, 32'h100);
    check("tgt_instr", if_id_instr, 32'h0);
    step();                                      // c16 WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    step();                                      // c17 ISSUE
    check("tgt_ld_instr",  if_id_instr, 32'h13);
    check("tgt_ld_pc",     if_id_pc, 32'h100);
    check("tgt_ld_opcode", {25'h0, if_id_opcode}, 32'h13);
    check("tgt_ld_addr",   imem_addr, 32'h104);

    // ---------------- Redirect same cycle as rvalid ----------------
    step();                                      // c18 WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    redirect = 1'b1; redirect_pc = 32'h200;
    step();                                      // c19 ISSUE
    check("rr_req",   {31'h0, imem_req}, 32'h1);
    check("rr_addr",  imem_addr, 32'h200);
    check("rr_valid", {31'h0, if_id_valid}, 32'h0);
    step();                                      // c20 WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
    step();                                      // c21 ISSUE
    check("rr_ld_instr", if_id_instr, 32'h33);

    // ---------------- Redirect with stall ----------------
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    step();                                      // c22 ISSUE
    check("rs_valid", {31'h0, if_id_valid}, 32'h0);
    check("rs_instr", if_id_instr, 32'h0);
    check("rs_addr",  imem_addr, 32'h300);
    stall = 1'b0;
    step();                                      // c23 WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_006F;
    step();                                      // c24 ISSUE
    check("rs_ld_pc",     if_id_pc, 32'h300);
    check("rs_ld_opcode", {25'h0, if_id_opcode}, 32'h6F);

    // ---------------- Three more fetches (total 10) ----------------
    for (int i = 0; i < 3; i++) begin
      step();                                    // WAIT
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_0100 + i;
      step();                                    // ISSUE
      check("loop_instr", if_id_instr, 32'h0000_0100 + i);
      check("loop_addr",  imem_addr, 32'h308 + 4 * i);
    end
`ifdef FETCH_PERF_EN
    exp_perf = 32'd10;
`else
    exp_perf = 32'd0;
`endif
    check("perf", perf_fetched, exp_perf);

    // ---------------- Reset mid-fetch ----------------
    step();                                      // WAIT
    rst = 1'b1;
    #1;
    check("mrst_valid", {31'h0, if_id_valid}, 32'h0);
    check("mrst_addr",  imem_addr, 32'h0);
    check("mrst_req",   {31'h0, imem_req}, 32'h0);
    check("mrst_perf",  perf_fetched, 32'h0);
    step();
    rst = 1'b0;                                  // IDLE
    imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;  // stray response
    step();                                      // ISSUE
    check("stray_req",   {31'h0, imem_req}, 32'h1);
    check("stray_addr",  imem_addr, 32'h0);
    check("stray_valid", {31'h0, if_id_valid}, 32'h0);
    step();                                      // WAIT
    check("stray_instr", if_id_instr, 32'h0);

    // ---------------- PC wrap ----------------
    rst_w = 1'b0;                                // IDLE
    step();                                      // ISSUE
    check("wrap_req",   {31'h0, req_w}, 32'h1);
    check("wrap_addr0", addr_w, 32'hFFFF_FFFC);
    step();                                      // WAIT
    rvalid_w = 1'b1; rdata_w = 32'h0000_00AA;
    step();                                      // ISSUE
    check("wrap_addr1", addr_w, 32'h0);
    check("wrap_pc",    pc_w, 32'hFFFF_FFFC);
    check("wrap_instr", instr_w, 32'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
